// File: rtl/datamemory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Ports: clk/reset, req/we/addr/wdata/ack/rdata per port, mem_* to the memory, busy, counters.
module datamemory_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wr_enable,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  count0,
  output logic [CNT_WIDTH-1:0]  count1
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic                  pick;

  // On a tie the port that did not win last time is served.
  assign pick = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (gnt_q) begin
          rdata1_d = mem_dout;
          if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 1'b1;
        end else begin
          rdata0_d = mem_dout;
          if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 1'b1;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  // Memory bus comes from the latched request; address/data hold between accesses.
  assign mem_address   = addr_q;
  assign mem_din       = wdata_q;
  assign mem_wr_enable = (state_q == ACCESS) & we_q;

  assign ack0   = (state_q == DONE) & ~gnt_q;
  assign ack1   = (state_q == DONE) & gnt_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != IDLE);
  assign count0 = cnt0_q;
  assign count1 = cnt1_q;

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Scoreboard bench for datamemory_arbiter with a behavioural memory model.
// Stimulus drives rounds of requests; a negedge monitor checks acks and writes.
module tb_datamemory_arbiter;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int CMAX = 65535;

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] data;
    int          cnt;
  } item_t;

  typedef struct {
    logic [16:0] a;
    logic [31:0] d;
  } wr_t;

  logic          clk = 0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_wr_enable, busy;
  logic [15:0]   count0, count1;

  logic          s_req0, s_ack0, s_ack1, s_wr, s_busy;
  logic [DW-1:0] s_rd0, s_rd1, s_din;
  logic [AW-1:0] s_addr0, s_maddr;
  logic [3:0]    s_c0, s_c1;

  logic [31:0] bmem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  item_t expq[$];
  wr_t   wq[$];
  logic [31:0] mdl [int];
  bit    mlast;
  int    mcnt [2];
  bit    prev_wr;

  always #5 clk = ~clk;

  datamemory_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_din(mem_din),
    .mem_wr_enable(mem_wr_enable), .mem_dout(mem_dout),
    .busy(busy), .count0(count0), .count1(count1)
  );

  datamemory_arbiter #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset),
    .req0(s_req0), .we0(1'b0), .addr0(s_addr0), .wdata0('0),
    .ack0(s_ack0), .rdata0(s_rd0),
    .req1(1'b0), .we1(1'b0), .addr1('0), .wdata1('0),
    .ack1(s_ack1), .rdata1(s_rd1),
    .mem_address(s_maddr), .mem_din(s_din),
    .mem_wr_enable(s_wr), .mem_dout(32'h0),
    .busy(s_busy), .count0(s_c0), .count1(s_c1)
  );

  initial for (int i = 0; i < (1<<AW); i++) bmem[i] = '0;

  always @(posedge clk)
    if (mem_wr_enable) bmem[mem_address] <= mem_din;

  assign mem_dout = bmem[mem_address];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected ack", nm);
  endtask

  function automatic logic [31:0] mread(int a);
    return mdl.exists(a) ? mdl[a] : 32'h0;
  endfunction

  task automatic model_reset();
    mlast   = 1;
    mcnt[0] = 0;
    mcnt[1] = 0;
  endtask

  // Scoreboard monitor: every ack and every write pulse is checked.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack0 && ack1) chk("dual ack", 1, 0);
      else if (ack0 || ack1) begin
        if (expq.size() == 0) chk("spurious ack", 1, 0);
        else begin
          item_t e;
          int p;
          p = ack1 ? 1 : 0;
          e = expq.pop_front();
          chk("grant port", p, e.port);
          if (!e.we)
            chk("rdata", p ? rdata1 : rdata0, e.data);
          chk("count", p ? count1 : count0, e.cnt);
        end
      end
      if (mem_wr_enable) begin
        chk("wr pulse width", prev_wr, 0);
        if (wq.size() == 0) chk("spurious write", 1, 0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr addr", mem_address, w.a);
          chk("wr data", mem_din, w.d);
        end
      end
    end
    prev_wr = mem_wr_enable;
  end

  task automatic issue(
    input bit e0, input bit w0, input int a0, input logic [31:0] d0,
    input bit e1, input bit w1, input int a1, input logic [31:0] d1
  );
    int ord[$];
    int t[$];
    int cyc;
    bit dn0, dn1;
    if (e0 && e1) ord = (mlast == 1) ? '{0, 1} : '{1, 0};
    else if (e0) ord = '{0};
    else if (e1) ord = '{1};
    foreach (ord[k]) begin
      item_t it;
      int p, a;
      bit w;
      logic [31:0] d;
      p = ord[k];
      w = p ? w1 : w0;
      a = p ? a1 : a0;
      d = p ? d1 : d0;
      it.port = p;
      it.we = w;
      it.data = 0;
      if (w) begin
        mdl[a] = d;
        wq.push_back('{a: a[16:0], d: d});
      end else it.data = mread(a);
      if (mcnt[p] != CMAX) mcnt[p]++;
      it.cnt = mcnt[p];
      mlast = p[0];
      expq.push_back(it);
    end
    req0 = e0; we0 = w0; addr0 = a0[16:0]; wdata0 = d0;
    req1 = e1; we1 = w1; addr1 = a1[16:0]; wdata1 = d1;
    dn0 = !e0;
    dn1 = !e1;
    cyc = 0;
    while (!(dn0 && dn1)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack0 && !dn0) begin dn0 = 1; req0 = 0; t.push_back(cyc); end
      if (ack1 && !dn1) begin dn1 = 1; req1 = 0; t.push_back(cyc); end
      if (cyc > 20) begin
        fail_now("ack wait");
        req0 = 0;
        req1 = 0;
        break;
      end
    end
    if (t.size() > 0) chk("ack latency", t[0], 2);
    if (t.size() > 1) chk("ack latency 2nd", t[1], 5);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    s_req0 = 0; s_addr0 = 0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst ack0", ack0, 0);
    chk("rst ack1", ack1, 0);
    chk("rst busy", busy, 0);
    chk("rst wren", mem_wr_enable, 0);
    chk("rst addr", mem_address, 0);
    chk("rst din", mem_din, 0);
    chk("rst rdata0", rdata0, 0);
    chk("rst rdata1", rdata1, 0);
    chk("rst count0", count0, 0);
    chk("rst count1", count1, 0);
    reset = 0;
    @(posedge clk);
    #1;

    // Contention straight from reset: port 0 reads the old value first.
    issue(1, 0, 1789, 0, 1, 1, 1789, 85);
    issue(1, 0, 1789, 0, 0, 0, 0, 0);

    // Single port write then read.
    issue(1, 1, 25, 1407, 0, 0, 0, 0);
    issue(1, 0, 25, 0, 0, 0, 0, 0);

    // Boundary addresses and data on port 1.
    issue(0, 0, 0, 0, 1, 1, (1<<AW)-1, 20);
    issue(0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF);
    issue(0, 0, 0, 0, 1, 0, (1<<AW)-1, 0);
    issue(0, 0, 0, 0, 1, 0, 0, 0);

    // Fairness: both ports always requesting.
    for (int i = 0; i < 6; i++)
      issue(1, 0, i, 0, 1, 0, i + 100, 0);

    // Reset in the middle of a write access.
    issue(1, 1, 5, 7, 0, 0, 0, 0);
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 99;
    @(posedge clk);
    #1;
    chk("mid wren before rst", mem_wr_enable, 1);
    reset = 1;
    #1;
    chk("mid rst wren", mem_wr_enable, 0);
    chk("mid rst ack0", ack0, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst addr", mem_address, 0);
    chk("mid rst count0", count0, 0);
    chk("mid rst rdata0", rdata0, 0);
    req0 = 0; we0 = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    @(posedge clk);
    #1;
    issue(1, 0, 5, 0, 0, 0, 0, 0);

    // Randomised rounds.
    for (int i = 0; i < 40; i++) begin
      int pat, a0, a1;
      pat = $urandom_range(1, 3);
      a0 = ($urandom_range(0, 9) == 0) ? (1<<AW)-1 : $urandom_range(0, 7);
      a1 = ($urandom_range(0, 9) == 0) ? (1<<AW)-1 : $urandom_range(0, 7);
      issue(pat[0], $urandom_range(0, 1), a0, $urandom,
            pat[1], $urandom_range(0, 1), a1, $urandom);
    end

    chk("pending acks", expq.size(), 0);
    chk("pending writes", wq.size(), 0);

    // Saturation on the narrow-counter instance.
    for (int i = 1; i <= 18; i++) begin
      int cyc;
      s_addr0 = i[16:0];
      s_req0 = 1;
      cyc = 0;
      while (!s_ack0 && cyc < 10) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      s_req0 = 0;
      if (!s_ack0) fail_now("sat ack wait");
      else chk("sat count0", s_c0, (i > 15) ? 15 : i);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
